// File: rtl/dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl_if
// Description : Handshaked data-memory port between the MEM-stage access
//               controller (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_ctrl_if #(
    parameter int addr_width = 32,
    parameter int data_width = 32
);
    logic                    mem_req;
    logic                    mem_we;
    logic [addr_width-1:0]   mem_addr;
    logic [3:0]              mem_be;
    logic [data_width-1:0]   mem_wdata;
    logic                    mem_ack;
    logic [data_width-1:0]   mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : MEM-stage data-memory access controller. Runs one handshaked
//               transaction per load/store, stalls the upstream pipeline
//               until it completes, steers byte stores onto the right lane
//               and sign-extends byte loads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  memory_rd_in,
    input  wire logic                  memory_wr_in,
    input  wire logic                  sb_w_in,
    input  wire logic                  lb_w_in,
    input  wire logic [addr_width-1:0] addr_in,
    input  wire logic [data_width-1:0] wdata_in,
    output logic                       stall,
    output logic [data_width-1:0]      load_data,
    output logic                       load_valid,
    output logic                       misalign_err,
    dmem_ctrl_if.master                bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic                    w_access;
    logic                    w_word;
    logic                    w_misalign;
    logic                    w_start;
    logic                    w_stall;
    logic                    w_load_done;
    logic [7:0]              w_byte;

    logic                    r_we;
    logic                    r_word;
    logic [1:0]              r_lane;
    logic [addr_width-1:0]   r_addr;
    logic [3:0]              r_be;
    logic [data_width-1:0]   r_wdata;
    logic [data_width-1:0]   r_load_data;
    logic                    r_load_valid;
    logic                    r_misalign;

    // A simultaneous read and write request is treated as a write, so the
    // size select follows the write strobe whenever it is set.
    assign w_access    = memory_rd_in | memory_wr_in;
    assign w_word      = memory_wr_in ? sb_w_in : lb_w_in;
    assign w_misalign  = w_access && w_word && (addr_in[1:0] != 2'b00);
    assign w_start     = (r_state == S_IDLE) && w_access && !w_misalign;
    assign w_load_done = (r_state == S_REQ) && bus.mem_ack && !r_we;
    assign w_byte      = bus.mem_rdata[{r_lane, 3'b000} +: 8];

    // Next-state and stall decode; stall is raised in the detect cycle so the
    // EX/MEM register holds the request while it is being serviced.
    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next  = S_REQ;
                    w_stall = 1'b1;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (bus.mem_ack) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the access when it is accepted; lane steering is resolved here so
    // the memory port sees stable values for the whole REQ phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_word  <= 1'b0;
            r_lane  <= 2'b00;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
        end else if (w_start) begin
            r_we   <= memory_wr_in;
            r_word <= w_word;
            r_lane <= addr_in[1:0];
            r_addr <= {addr_in[addr_width-1:2], 2'b00};
            if (memory_wr_in) begin
                if (w_word) begin
                    r_be    <= 4'b1111;
                    r_wdata <= wdata_in;
                end else begin
                    r_be    <= 4'b0001 << addr_in[1:0];
                    r_wdata <= {4{wdata_in[7:0]}};
                end
            end else begin
                r_be    <= 4'b1111;
                r_wdata <= '0;
            end
        end
    end

    // Capture load data on ack; the valid pulse lines up with the DONE cycle
    // and load_data holds until the next load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
        end else begin
            r_load_valid <= w_load_done;
            if (w_load_done) begin
                if (r_word) begin
                    r_load_data <= bus.mem_rdata;
                end else begin
                    r_load_data <= {{(data_width-8){w_byte[7]}}, w_byte};
                end
            end
        end
    end

    // Misaligned word accesses are dropped and flagged one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) && w_misalign;
        end
    end

    assign stall         = w_stall && !rst;
    assign load_data     = r_load_data;
    assign load_valid    = r_load_valid;
    assign misalign_err  = r_misalign;

    assign bus.mem_req   = (r_state == S_REQ);
    assign bus.mem_we    = (r_state == S_REQ) && r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_be    = r_be;
    assign bus.mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench for dmem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        memory_rd_in;
    logic        memory_wr_in;
    logic        sb_w_in;
    logic        lb_w_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign_err;

    int vectors;
    int miscompares;

    dmem_ctrl_if #(.addr_width(32), .data_width(32)) bus ();

    dmem_ctrl #(.addr_width(32), .data_width(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .memory_rd_in (memory_rd_in),
        .memory_wr_in (memory_wr_in),
        .sb_w_in      (sb_w_in),
        .lb_w_in      (lb_w_in),
        .addr_in      (addr_in),
        .wdata_in     (wdata_in),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign_err (misalign_err),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        memory_rd_in = 1'b1;
        lb_w_in = 1'b1;
        addr_in = 32'h0000_0100;
        tick();
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b exp=0", stall); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%b exp=0", bus.mem_req); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        vectors++; if (load_valid !== 1'b0) begin miscompares++; $display("FAIL rst_load_valid got=%b exp=0", load_valid); end
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
        vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL rst_load_data got=%h exp=0", load_data); end
        vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        vectors++; if (bus.mem_be !== 4'h0) begin miscompares++; $display("FAIL rst_mem_be got=%h exp=0", bus.mem_be); end
        vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
        tick();
        rst = 1'b0;
        memory_rd_in = 1'b0;
        tick();
    endtask

    task automatic test_word_load();
        memory_rd_in = 1'b1; lb_w_in = 1'b1; addr_in = 32'h0000_0100;
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL wl_c0_stall got=%b exp=1", stall); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL wl_c0_req got=%b exp=0", bus.mem_req); end
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL wl_c1_stall got=%b exp=1", stall); end
        vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL wl_c1_req got=%b exp=1", bus.mem_req); end
        vectors++; if (bus.mem_addr !== 32'h0000_0100) begin miscompares++; $display("FAIL wl_addr got=%h exp=00000100", bus.mem_addr); end
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL wl_we got=%b exp=0", bus.mem_we); end
        vectors++; if (bus.mem_be !== 4'hF) begin miscompares++; $display("FAIL wl_be got=%h exp=f", bus.mem_be); end
        vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL wl_wdata got=%h exp=0", bus.mem_wdata); end
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL wl_c2_stall got=%b exp=0", stall); end
        vectors++; if (load_valid !== 1'b1) begin miscompares++; $display("FAIL wl_c2_valid got=%b exp=1", load_valid); end
        vectors++; if (load_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wl_data got=%h exp=deadbeef", load_data); end
        tick();
        memory_rd_in = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        vectors++; if (load_valid !== 1'b0) begin miscompares++; $display("FAIL wl_c3_valid got=%b exp=0", load_valid); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL nonmem_stall got=%b exp=0", stall); end
        tick();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0 || load_valid !== 1'b0) begin miscompares++; $display("FAIL idle_ack_ignored got=%b%b exp=00", bus.mem_req, load_valid); end
        tick();
    endtask

    task automatic test_byte_store();
        int stall_cnt;
        int req_cnt;
        stall_cnt = 0;
        req_cnt = 0;
        sb_w_in = 1'b0; addr_in = 32'h0000_0203; wdata_in = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            memory_wr_in = (i <= 5);
            bus.mem_ack = (i == 4);
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus.mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    vectors++; if (bus.mem_be !== 4'b1000) begin miscompares++; $display("FAIL bs_be got=%b exp=1000", bus.mem_be); end
                    vectors++; if (bus.mem_wdata !== 32'h7878_7878) begin miscompares++; $display("FAIL bs_wdata got=%h exp=78787878", bus.mem_wdata); end
                    vectors++; if (bus.mem_addr !== 32'h0000_0200) begin miscompares++; $display("FAIL bs_addr got=%h exp=00000200", bus.mem_addr); end
                    vectors++; if (bus.mem_we !== 1'b1) begin miscompares++; $display("FAIL bs_we got=%b exp=1", bus.mem_we); end
                end
            end
            if (i == 5) begin
                vectors++; if (load_valid !== 1'b0) begin miscompares++; $display("FAIL bs_no_valid got=%b exp=0", load_valid); end
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        memory_wr_in = 1'b0;
        vectors++; if (req_cnt != 4) begin miscompares++; $display("FAIL bs_req_cycles got=%0d exp=4", req_cnt); end
        vectors++; if (stall_cnt != 5) begin miscompares++; $display("FAIL bs_stall_cycles got=%0d exp=5", stall_cnt); end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd_vals [2];
        logic [31:0] exp_vals [2];
        rd_vals[0] = 32'h00A5_0000; exp_vals[0] = 32'hFFFF_FFA5;
        rd_vals[1] = 32'h0035_0000; exp_vals[1] = 32'h0000_0035;
        for (int k = 0; k < 2; k++) begin
            memory_rd_in = 1'b1; lb_w_in = 1'b0; addr_in = 32'h0000_0102;
            tick();
            bus.mem_ack = 1'b1; bus.mem_rdata = rd_vals[k];
            tick();
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
            @(negedge clk);
            vectors++; if (load_valid !== 1'b1) begin miscompares++; $display("FAIL bl%0d_valid got=%b exp=1", k, load_valid); end
            vectors++; if (load_data !== exp_vals[k]) begin miscompares++; $display("FAIL bl%0d_data got=%h exp=%h", k, load_data, exp_vals[k]); end
            tick();
            memory_rd_in = 1'b0;
            tick();
            @(negedge clk);
            vectors++; if (load_data !== exp_vals[k]) begin miscompares++; $display("FAIL bl%0d_hold got=%h exp=%h", k, load_data, exp_vals[k]); end
            tick();
        end
    endtask

    task automatic test_misalign();
        memory_wr_in = 1'b1; sb_w_in = 1'b1; addr_in = 32'h0000_0006; wdata_in = 32'hCAFE_F00D;
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL ma_stall got=%b exp=0", stall); end
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL ma_c0_err got=%b exp=0", misalign_err); end
        tick();
        memory_wr_in = 1'b0;
        @(negedge clk);
        vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL ma_c1_err got=%b exp=1", misalign_err); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL ma_req got=%b exp=0", bus.mem_req); end
        tick();
        @(negedge clk);
        vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL ma_c2_err got=%b exp=0", misalign_err); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL ma_c2_req got=%b exp=0", bus.mem_req); end
        tick();
    endtask

    task automatic test_reset_mid();
        memory_rd_in = 1'b1; lb_w_in = 1'b1; addr_in = 32'h0000_0040;
        tick();
        tick();
        rst = 1'b1;
        memory_rd_in = 1'b0;
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rm_stall_in_rst got=%b exp=0", stall); end
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
        @(negedge clk);
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req got=%b exp=0", bus.mem_req); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rm_stall got=%b exp=0", stall); end
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk);
        vectors++; if (load_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_valid got=%b exp=0", load_valid); end
        vectors++; if (bus.mem_req !== 1'b0) begin miscompares++; $display("FAIL rm_idle_req got=%b exp=0", bus.mem_req); end
        tick();
        memory_rd_in = 1'b1; lb_w_in = 1'b1; addr_in = 32'h0000_0044;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        vectors++; if (bus.mem_addr !== 32'h0000_0044) begin miscompares++; $display("FAIL rm_next_addr got=%h exp=00000044", bus.mem_addr); end
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        @(negedge clk);
        vectors++; if (load_valid !== 1'b1 || load_data !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL rm_next_load got=%b/%h exp=1/0badf00d", load_valid, load_data); end
        tick();
        memory_rd_in = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        int k;
        int c;
        int nvalid;
        int valid_cyc [2];
        logic [31:0] valid_dat [2];
        int first_req [2];
        int nreq;
        addrs[0] = 32'h0000_0300; datas[0] = 32'hA1B2_C3D4;
        addrs[1] = 32'h0000_0304; datas[1] = 32'h5566_7788;
        k = 0; c = 0; nvalid = 0; nreq = 0;
        valid_cyc[0] = -1; valid_cyc[1] = -1;
        valid_dat[0] = '0; valid_dat[1] = '0;
        first_req[0] = -1; first_req[1] = -1;
        while (k < 2 && c < 20) begin
            memory_rd_in = 1'b1; lb_w_in = 1'b1; addr_in = addrs[k];
            bus.mem_ack = bus.mem_req;
            bus.mem_rdata = datas[k];
            @(negedge clk);
            if (bus.mem_req && nreq < 2 && (nreq == 0 || first_req[nreq-1] != c - 1)) begin
                first_req[nreq] = c;
                nreq++;
            end
            if (load_valid && nvalid < 2) begin
                valid_cyc[nvalid] = c;
                valid_dat[nvalid] = load_data;
                nvalid++;
            end
            if (!stall) k++;
            tick();
            c++;
        end
        memory_rd_in = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        vectors++; if (c != 6) begin miscompares++; $display("FAIL b2b_cycles got=%0d exp=6", c); end
        vectors++; if (first_req[1] != 4) begin miscompares++; $display("FAIL b2b_req2_cycle got=%0d exp=4", first_req[1]); end
        vectors++; if (valid_cyc[0] != 2 || valid_dat[0] !== 32'hA1B2_C3D4) begin miscompares++; $display("FAIL b2b_load0 got=c%0d/%h exp=c2/a1b2c3d4", valid_cyc[0], valid_dat[0]); end
        vectors++; if (valid_cyc[1] != 5 || valid_dat[1] !== 32'h5566_7788) begin miscompares++; $display("FAIL b2b_load1 got=c%0d/%h exp=c5/55667788", valid_cyc[1], valid_dat[1]); end
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        memory_rd_in = 1'b0; memory_wr_in = 1'b0;
        sb_w_in = 1'b0; lb_w_in = 1'b0;
        addr_in = '0; wdata_in = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller for the MEM stage of the RV32 pipeline. It takes the access request held in the EX/MEM pipeline register: the read/write strobes, the byte/word selects, the address from ALU_result and the store data from rs2. It runs one handshaked transaction on the external data-memory port and holds the upstream pipeline with `stall` until the transaction completes. It also performs byte-lane steering for byte stores and sign extension for byte loads.

## Interface

Parameters:
- `addr_width`, 32, width of the byte address and of `mem_addr`.
- `data_width`, 32, width of data paths; fixed at 32 (4 byte lanes).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `memory_rd_in`  in  1  load request from EX/MEM.
- `memory_wr_in`  in  1  store request from EX/MEM.
- `sb_w_in`  in  1  store size: 1 = word, 0 = byte.
- `lb_w_in`  in  1  load size: 1 = word, 0 = byte.
- `addr_in`  in  addr_width  byte address (ALU_result).
- `wdata_in`  in  32  store data (rs2).
- `stall`  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- `load_data`  out  32  load result for MEM/WB.
- `load_valid`  out  1  one-cycle pulse: `load_data` is valid.
- `misalign_err`  out  1  one-cycle pulse: word access with addr[1:0] != 0.
- `mem_req`  out  1  transaction request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  addr_width  word-aligned address, {addr[addr_width-1:2], 2'b00}.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  write data.
- `mem_ack`  in  1  memory completes the transaction this cycle; for reads, `mem_rdata` is valid.
- `mem_rdata`  in  32  read data.

## Operation

- FSM states: IDLE, REQ, DONE. Reset puts the FSM in IDLE.
- **IDLE:**
  - An access is present when `memory_rd_in` or `memory_wr_in` is 1.
  - If both are 1, the access is treated as a write.
  - A word access with addr[1:0] != 0 is misaligned:
    - no request is issued; `stall` = 0;
    - `misalign_err` pulses on the next cycle;
    - the FSM stays in IDLE.
  - A valid access:
    - latch op, size, addr and wdata;
    - `stall` = 1 combinationally in the same cycle;
    - go to REQ.
- **REQ:**
  - `mem_req` = 1; `stall` = 1.
  - `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` come from the latched values and are stable until ack.
  - On `mem_ack`:
    - capture `mem_rdata`, processed per the load rules below;
    - go to DONE.
  - Without ack, the FSM stays in REQ indefinitely.
- **DONE:**
  - `stall` = 0, so the pipeline advances at the end of this cycle.
  - `load_valid` = 1 if the access was a load.
  - EX/MEM inputs still show the finished instruction and are ignored.
  - Unconditionally go to IDLE.
- **Store steering:**
  - Word store: `mem_be` = 4'b1111, `mem_wdata` = wdata.
  - Byte store: `mem_be` = 4'b0001 << addr[1:0], `mem_wdata` = {4{wdata[7:0]}}.
- **Load:**
  - Word load: `load_data` = `mem_rdata`.
  - Byte load:
    - selected byte = `mem_rdata`[8*addr[1:0] +: 8];
    - `load_data` = that byte sign-extended to 32 bits.
  - During a load, `mem_be` is 4'b1111 and `mem_wdata` is 0.
- `mem_ack` outside REQ is ignored.
- `load_data` holds its last value until the next load completes.

## Timing

- Reset values:
  - FSM state IDLE.
  - `mem_req`, `mem_we`, `load_valid`, `misalign_err` = 0.
  - `load_data`, `mem_addr`, `mem_be`, `mem_wdata` = 0.
  - `stall` is forced to 0 while `rst` = 1.
- Reset during REQ:
  - next state is IDLE and `mem_req` = 0 from the next cycle;
  - a late ack is ignored;
  - no `load_valid` is produced.
- Latency with ack in the first REQ cycle is 3 cycles per access:
  - cycle 0: IDLE detects the access, `stall` = 1;
  - cycle 1: REQ, ack arrives;
  - cycle 2: DONE, `load_valid` = 1.
- Each ack delay of N cycles adds N cycles.
- `stall` is high for exactly (2 + ack delay) cycles per access.
- Back-to-back accesses: the next access is detected in the cycle after DONE, with no idle gap beyond that cycle.
- Non-memory instructions pass with 0 added cycles.

## Test plan

- Word load, addr 0x100, ack in first REQ cycle, `mem_rdata` = 0xDEADBEEF:
  - `stall` high for cycles 0–1;
  - `mem_addr` = 0x100, `mem_we` = 0;
  - cycle 2: `load_valid` = 1, `load_data` = 0xDEADBEEF.
- Byte store, addr 0x203, wdata 0x12345678, ack delayed 3 cycles:
  - `mem_req` high 4 cycles;
  - `mem_be` = 4'b1000, `mem_wdata` = 0x78787878, `mem_addr` = 0x200;
  - `stall` high 5 cycles.
- Byte load, addr 0x102, `mem_rdata` = 0x00A50000: `load_data` = 0xFFFFFFA5. Same test with 0x00350000: `load_data` = 0x00000035.
- Word store, addr 0x006:
  - no `mem_req`, `stall` stays 0;
  - `misalign_err` pulses once on the next cycle.
- Reset mid-transaction:
  - assert `rst` in the second REQ cycle of a load, then ack on the following cycle;
  - required: `mem_req` = 0 after reset, no `load_valid`, state IDLE, next load completes normally.
- Two back-to-back loads (EX/MEM advances only when `stall` = 0):
  - second request begins the cycle after the first DONE;
  - total 6 cycles;
  - both `load_valid` pulses carry the correct data.
